bin_to_bcd_seq: RTL

//  Sequential binary-to-BCD converter (shift-and-add-3 / double dabble) feeding the 2-digit BCD adder.

---
 rtl/bcd_pkg.sv | 8 +
 rtl/bin_to_bcd_seq_if.sv | 23 ++
 rtl/bcd_digit_adj.sv | 9 +
 rtl/bin_to_bcd_seq.sv | 98 +++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD types and constants for the converter and adder stages
package bcd_pkg;
    localparam int BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESH = 4'd5;

    typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} b2b_state_t;
endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// rtl/bin_to_bcd_seq_if.sv - operand/result handshake bundle for bin_to_bcd_seq
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [BIN_W-1:0]      in_bin;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  ovf99;

    modport master (
        output in_valid, in_bin, out_ready,
        input  in_ready, out_valid, bcd_out, ovf99
    );

    modport slave (
        input  in_valid, in_bin, out_ready,
        output in_ready, out_valid, bcd_out, ovf99
    );
endinterface

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - add-3 correction for one BCD digit ahead of a double-dabble shift
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  bcd_digit_t d,
    output bcd_digit_t q
);
    assign q = (d >= ADJ_THRESH) ? d + 4'd3 : d;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential double-dabble binary to packed-BCD converter
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic            clk,
    input  logic            rst,
    bin_to_bcd_seq_if.slave bus
);
    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W);

    b2b_state_t              state, state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [BIN_W-1:0]        bin_sr;
    logic [BCD_W-1:0]        scratch;
    logic [BCD_W-1:0]        scratch_adj;
    logic [BCD_W-1:0]        bcd_q;
    logic [BCD_W+BIN_W-1:0]  shifted;
    logic                    last_iter;
    logic                    in_ready_c;
    logic                    out_valid_c;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d(scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .q(scratch_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // The top bit of the adjusted scratch falls off; DIGITS is sized so it is always zero.
    assign shifted   = {scratch_adj, bin_sr} << 1;
    assign last_iter = (cnt == CNT_W'(BIN_W - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (last_iter) state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            bin_sr  <= '0;
            scratch <= '0;
            bcd_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        bin_sr  <= bus.in_bin;
                        scratch <= '0;
                        cnt     <= '0;
                    end
                end
                S_SHIFT: begin
                    scratch <= shifted[BCD_W+BIN_W-1:BIN_W];
                    bin_sr  <= shifted[BIN_W-1:0];
                    cnt     <= cnt + 1'b1;
                    if (last_iter) bcd_q <= shifted[BCD_W+BIN_W-1:BIN_W];
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.bcd_out   = bcd_q;

    // Anything in the hundreds digit or above is out of range for the 2-digit adder.
    if (DIGITS > 2) begin : g_ovf
        assign bus.ovf99 = |bcd_q[BCD_W-1:2*BCD_DIGIT_W];
    end else begin : g_no_ovf
        assign bus.ovf99 = 1'b0;
    end
endmodule
